unit_normalize: RTL and testbench

Post-add/sub normalization stage of the floating-point unit datapath. Takes the biased exponent and 28-bit working mantissa (hidden bit plus guard/round/sticky) from the adder. It then either right-shifts by one on carry-out, or left-normalizes by the leading-zero count. It flags exponent overflow and underflow, and handles zero results and the special exponent 255. Outputs are registered and feed the rounding stage.

---
 rtl/fpu_pkg.sv | 19 +
 rtl/lzc28.sv | 35 +++
 rtl/unit_normalize.sv | 107 ++++++++++
 tb/tb_unit_normalize.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU datapath definitions.
// Widths, special exponent and the normalized-result bundle.
package fpu_pkg;

    localparam int EXP_W = 8;
    localparam int MANT_W = 28;
    localparam int LZC_W = 5;

    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;
    localparam logic [EXP_W-1:0] EXP_ZERO = 8'h00;

    typedef struct packed {
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic              ov;
        logic              un;
    } norm_t;

endpackage

// File: rtl/lzc28.sv
// 28-bit leading-zero counter, binary tree encoder.
// All-zero input yields 28.
module lzc28 (
    input  logic [27:0] mant_i,
    output logic [4:0]  cnt_o
);

    logic [31:0] pad;
    logic [15:0] y16;
    logic [7:0]  y8;
    logic [3:0]  y4;
    logic [1:0]  y2;
    logic        z16;
    logic        z8;
    logic        z4;
    logic        z2;
    logic        z1;

    // Pad low end with ones so the count saturates at 28,
    // then halve the window each level toward the first one.
    always_comb begin
        pad = {mant_i, 4'hF};
        z16 = ~|pad[31:16];
        y16 = z16 ? pad[15:0] : pad[31:16];
        z8 = ~|y16[15:8];
        y8 = z8 ? y16[7:0] : y16[15:8];
        z4 = ~|y8[7:4];
        y4 = z4 ? y8[3:0] : y8[7:4];
        z2 = ~|y4[3:2];
        y2 = z2 ? y4[1:0] : y4[3:2];
        z1 = ~y2[1];
        cnt_o = {z16, z8, z4, z2, z1};
    end

endmodule

// File: rtl/unit_normalize.sv
// Post-add/sub normalization stage of the FPU.
// Right-shift on carry, else left-normalize by LZC; 1-cycle latency.
module unit_normalize
    import fpu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              aos_alu,
    input  logic [EXP_W-1:0]  i_exp,
    input  logic [MANT_W-1:0] i_mant,
    input  logic              c_alu,
    output logic [EXP_W-1:0]  o_exp,
    output logic [MANT_W-1:0] o_mant,
    output logic              o_ov_fl,
    output logic              o_un_fl
);

    logic [LZC_W-1:0]  lz_cnt;
    logic [EXP_W-1:0]  lz_ext;
    logic [MANT_W-1:0] sh1;
    logic [MANT_W-1:0] sh2;
    logic [MANT_W-1:0] sh4;
    logic [MANT_W-1:0] sh8;
    logic [MANT_W-1:0] shl;
    logic [EXP_W-1:0]  exp_inc;
    logic [EXP_W-1:0]  exp_sub;
    logic [EXP_W-1:0]  exp_sat;
    logic              sel;
    logic              mant_zero;
    logic              is_zero;
    norm_t             res_d;
    norm_t             res_q;

    lzc28 u_lzc (
        .mant_i (i_mant),
        .cnt_o  (lz_cnt)
    );

    // Barrel shifter: one stage per bit of the leading-zero count.
    always_comb begin
        sh1 = lz_cnt[0] ? {i_mant[26:0], 1'b0} : i_mant;
        sh2 = lz_cnt[1] ? {sh1[25:0], 2'b0} : sh1;
        sh4 = lz_cnt[2] ? {sh2[23:0], 4'b0} : sh2;
        sh8 = lz_cnt[3] ? {sh4[19:0], 8'b0} : sh4;
        shl = lz_cnt[4] ? {sh8[11:0], 16'b0} : sh8;
    end

    // Exponent arithmetic and zero-result detection.
    always_comb begin
        lz_ext = {3'b000, lz_cnt};
        exp_inc = i_exp + 8'd1;
        exp_sub = i_exp - lz_ext;
        exp_sat = (i_exp > lz_ext) ? exp_sub : EXP_ZERO;
        sel = (i_exp == EXP_SPECIAL);
        mant_zero = (i_mant == '0);
        if (aos_alu) begin
            is_zero = ~c_alu & (i_exp == EXP_ZERO) & mant_zero;
        end else begin
            is_zero = ~c_alu & mant_zero;
        end
    end

    // Result select: special exponent, zero, carry, left-normalize.
    always_comb begin
        res_d = '0;
        unique case (1'b1)
            sel & c_alu: begin
                res_d.exp = EXP_SPECIAL;
                res_d.mant = i_mant;
                res_d.ov = 1'b1;
            end
            sel & ~c_alu: begin
                res_d.exp = EXP_SPECIAL - lz_ext;
                res_d.mant = shl;
                res_d.ov = (lz_cnt == '0);
            end
            ~sel & is_zero: begin
                res_d.un = 1'b1;
            end
            ~sel & ~is_zero & c_alu: begin
                res_d.exp = exp_inc;
                res_d.mant = {1'b0, i_mant[MANT_W-1:1]};
                res_d.ov = (exp_inc == EXP_SPECIAL);
            end
            default: begin
                res_d.exp = exp_sat;
                res_d.mant = shl;
                res_d.un = (exp_sat == EXP_ZERO);
            end
        endcase
    end

    // Output register, cleared asynchronously.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign o_exp = res_q.exp;
    assign o_mant = res_q.mant;
    assign o_ov_fl = res_q.ov;
    assign o_un_fl = res_q.un;

endmodule

// File: tb/tb_unit_normalize.sv
// Self-checking bench for unit_normalize.
// Directed plan vectors plus random vectors vs a behavioural model.
module tb_unit_normalize;
    import fpu_pkg::*;

    logic        i_clk;
    logic        i_rst;
    logic        aos_alu;
    logic [7:0]  i_exp;
    logic [27:0] i_mant;
    logic        c_alu;
    logic [7:0]  o_exp;
    logic [27:0] o_mant;
    logic        o_ov_fl;
    logic        o_un_fl;

    int checks = 0;
    int failures = 0;

    unit_normalize dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .aos_alu (aos_alu),
        .i_exp   (i_exp),
        .i_mant  (i_mant),
        .c_alu   (c_alu),
        .o_exp   (o_exp),
        .o_mant  (o_mant),
        .o_ov_fl (o_ov_fl),
        .o_un_fl (o_un_fl)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference: counts leading zeros by scanning, then applies the rules.
    function automatic norm_t model(input logic [7:0] e, input logic [27:0] m,
                                    input logic c, input logic a);
        norm_t r;
        int n;
        int ei;
        logic zero;
        r = '0;
        n = 0;
        while (n < 28 && m[27-n] == 1'b0) n++;
        if (e == 8'd255) begin
            if (c) begin
                r.exp = 8'd255;
                r.mant = m;
                r.ov = 1'b1;
            end else begin
                r.exp = 8'(255 - n);
                r.mant = m << n;
                r.ov = (n == 0);
            end
        end else begin
            zero = !c && (a ? (e == 0 && m == 0) : (m == 0));
            if (zero) begin
                r.un = 1'b1;
            end else if (c) begin
                ei = int'(e) + 1;
                r.exp = 8'(ei);
                r.mant = m >> 1;
                r.ov = (ei == 255);
            end else begin
                ei = int'(e) - n;
                if (ei < 0) ei = 0;
                r.exp = 8'(ei);
                r.mant = m << n;
                r.un = (ei == 0);
            end
        end
        return r;
    endfunction

    task automatic drive(input logic [7:0] e, input logic [27:0] m,
                         input logic c, input logic a);
        @(negedge i_clk);
        i_exp = e;
        i_mant = m;
        c_alu = c;
        aos_alu = a;
        @(posedge i_clk);
        #1;
    endtask

    task automatic rand_vec(output logic [7:0] e, output logic [27:0] m,
                            output logic c, output logic a, input bit special);
        m = 28'($urandom) >> $urandom_range(0, 28);
        c = 1'($urandom);
        a = 1'($urandom);
        if (special) e = 8'hFF;
        else if ($urandom_range(0, 1) == 1) e = 8'($urandom_range(0, 30));
        else e = 8'($urandom_range(0, 254));
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_exp = 8'hFE;
        i_mant = 28'hFFFFFFF;
        c_alu = 1'b1;
        aos_alu = 1'b1;
        @(posedge i_clk);
        #1;
        checks++;
        if ({o_exp, o_mant, o_ov_fl, o_un_fl} !== 38'd0) begin
            failures++;
            $display("FAIL reset got=%h want=0", {o_exp, o_mant, o_ov_fl, o_un_fl});
        end
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic test_special();
        drive(8'hFF, 28'h1234567, 1'b1, 1'b0);
        checks++;
        if ({o_exp, o_mant, o_ov_fl, o_un_fl} !== {8'hFF, 28'h1234567, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL special_hold got=%h/%h/%b%b want=ff/1234567/10", o_exp, o_mant, o_ov_fl, o_un_fl);
        end
        drive(8'hFF, 28'h0800000, 1'b0, 1'b1);
        checks++;
        if ({o_exp, o_mant, o_ov_fl, o_un_fl} !== {8'hFB, 28'h8000000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL special_norm got=%h/%h/%b%b want=fb/8000000/00", o_exp, o_mant, o_ov_fl, o_un_fl);
        end
        drive(8'hFF, 28'h8000000, 1'b0, 1'b0);
        checks++;
        if ({o_exp, o_mant, o_ov_fl, o_un_fl} !== {8'hFF, 28'h8000000, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL special_n0 got=%h/%h/%b%b want=ff/8000000/10", o_exp, o_mant, o_ov_fl, o_un_fl);
        end
        drive(8'hFF, 28'h0, 1'b0, 1'b0);
        checks++;
        if ({o_exp, o_mant, o_ov_fl, o_un_fl} !== {8'd227, 28'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL special_zero got=%h/%h/%b%b want=e3/0000000/00", o_exp, o_mant, o_ov_fl, o_un_fl);
        end
    endtask

    task automatic test_carry();
        drive(8'hFE, 28'h000000A, 1'b1, 1'b0);
        checks++;
        if ({o_exp, o_mant, o_ov_fl, o_un_fl} !== {8'hFF, 28'h0000005, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL carry_ov got=%h/%h/%b%b want=ff/0000005/10", o_exp, o_mant, o_ov_fl, o_un_fl);
        end
        drive(8'h10, 28'h000000A, 1'b1, 1'b1);
        checks++;
        if ({o_exp, o_mant, o_ov_fl, o_un_fl} !== {8'h11, 28'h0000005, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL carry_norm got=%h/%h/%b%b want=11/0000005/00", o_exp, o_mant, o_ov_fl, o_un_fl);
        end
    endtask

    task automatic test_left_norm();
        drive(8'h10, 28'h0000001, 1'b0, 1'b0);
        checks++;
        if ({o_exp, o_mant, o_ov_fl, o_un_fl} !== {8'h00, 28'h8000000, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL lnorm_sat got=%h/%h/%b%b want=00/8000000/01", o_exp, o_mant, o_ov_fl, o_un_fl);
        end
        drive(8'h40, 28'h0000001, 1'b0, 1'b0);
        checks++;
        if ({o_exp, o_mant, o_ov_fl, o_un_fl} !== {8'h25, 28'h8000000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL lnorm got=%h/%h/%b%b want=25/8000000/00", o_exp, o_mant, o_ov_fl, o_un_fl);
        end
    endtask

    task automatic test_zero();
        drive(8'h40, 28'h0, 1'b0, 1'b0);
        checks++;
        if ({o_exp, o_mant, o_ov_fl, o_un_fl} !== {8'h00, 28'h0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL zero_add got=%h/%h/%b%b want=00/0000000/01", o_exp, o_mant, o_ov_fl, o_un_fl);
        end
        drive(8'h40, 28'h0, 1'b0, 1'b1);
        checks++;
        if ({o_exp, o_mant, o_ov_fl, o_un_fl} !== {8'h24, 28'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL zero_sub_exp got=%h/%h/%b%b want=24/0000000/00", o_exp, o_mant, o_ov_fl, o_un_fl);
        end
        drive(8'h00, 28'h0, 1'b0, 1'b1);
        checks++;
        if ({o_exp, o_mant, o_ov_fl, o_un_fl} !== {8'h00, 28'h0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL zero_sub got=%h/%h/%b%b want=00/0000000/01", o_exp, o_mant, o_ov_fl, o_un_fl);
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] e;
        logic [27:0] m;
        logic c;
        logic a;
        norm_t exp_r;
        for (int i = 0; i < 8; i++) begin
            rand_vec(e, m, c, a, (i % 2) == 0);
            exp_r = model(e, m, c, a);
            drive(e, m, c, a);
            checks++;
            if ({o_exp, o_mant, o_ov_fl, o_un_fl} !== exp_r) begin
                failures++;
                $display("FAIL b2b[%0d] got=%h want=%h", i, {o_exp, o_mant, o_ov_fl, o_un_fl}, exp_r);
            end
        end
        #2;
        i_rst = 1'b1;
        #1;
        checks++;
        if ({o_exp, o_mant, o_ov_fl, o_un_fl} !== 38'd0) begin
            failures++;
            $display("FAIL async_rst got=%h want=0", {o_exp, o_mant, o_ov_fl, o_un_fl});
        end
        drive(8'hFF, 28'h1234567, 1'b1, 1'b0);
        checks++;
        if ({o_exp, o_mant, o_ov_fl, o_un_fl} !== 38'd0) begin
            failures++;
            $display("FAIL rst_hold got=%h want=0", {o_exp, o_mant, o_ov_fl, o_un_fl});
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rand_vec(e, m, c, a, (i % 2) == 1);
            exp_r = model(e, m, c, a);
            drive(e, m, c, a);
            checks++;
            if ({o_exp, o_mant, o_ov_fl, o_un_fl} !== exp_r) begin
                failures++;
                $display("FAIL post_rst[%0d] got=%h want=%h", i, {o_exp, o_mant, o_ov_fl, o_un_fl}, exp_r);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] e;
        logic [27:0] m;
        logic c;
        logic a;
        norm_t exp_r;
        for (int i = 0; i < 200; i++) begin
            rand_vec(e, m, c, a, (i % 2) == 0);
            exp_r = model(e, m, c, a);
            drive(e, m, c, a);
            checks++;
            if ({o_exp, o_mant, o_ov_fl, o_un_fl} !== exp_r) begin
                failures++;
                $display("FAIL rand[%0d] in=%h/%h/c%b/a%b got=%h want=%h",
                         i, e, m, c, a, {o_exp, o_mant, o_ov_fl, o_un_fl}, exp_r);
            end
            checks++;
            if (o_ov_fl && o_un_fl) begin
                failures++;
                $display("FAIL flags_excl[%0d] got=11 want=not both", i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_special();
        test_carry();
        test_left_norm();
        test_zero();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
